// File: rtl/sequence_store.sv
// Colour sequence store: appends up to DEPTH colours, replays them over a valid/advance handshake
// and checks player presses against them. Optional seq_flat snapshot via SEQ_STORE_SNAPSHOT_EN.
module sequence_store #(
  parameter int COLOUR_W = 2,
  parameter int DEPTH    = 32,
  parameter int LEN_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                load,
  input  logic [COLOUR_W-1:0] new_colour,
  input  logic                play_start,
  input  logic                play_adv,
  output logic [COLOUR_W-1:0] play_colour,
  output logic                play_valid,
  output logic                play_last,
  input  logic                chk_start,
  input  logic                chk_valid,
  input  logic [COLOUR_W-1:0] chk_colour,
  output logic                chk_done,
  output logic                chk_miss,
  output logic [LEN_W-1:0]    chk_idx,
  output logic [LEN_W-1:0]    length,
  output logic                full,
  output logic                busy
`ifdef SEQ_STORE_SNAPSHOT_EN
  ,
  output logic [DEPTH*COLOUR_W-1:0] seq_flat
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, PLAY, CHECK} state_t;

  // Replay handshake: play_colour is offered while play_valid=1; the consumer
  // accepts it by raising play_adv, and the next entry appears the cycle after.
  state_t                state, state_n;
  logic [COLOUR_W-1:0]   mem [DEPTH];
  logic [LEN_W-1:0]      length_n, rd_ptr, rd_ptr_n, rd_ptr_inc, chk_idx_n, last_idx;
  logic [COLOUR_W-1:0]   play_colour_n;
  logic                  play_valid_n, chk_done_n, chk_miss_n, wr_en;

  assign full       = (length == LEN_W'(DEPTH));
  assign busy       = (state != IDLE);
  assign last_idx   = length - LEN_W'(1);
  assign rd_ptr_inc = rd_ptr + LEN_W'(1);
  assign play_last  = play_valid && (rd_ptr == last_idx);

  always_comb begin
    state_n       = state;
    length_n      = length;
    rd_ptr_n      = rd_ptr;
    play_colour_n = play_colour;
    play_valid_n  = play_valid;
    chk_idx_n     = chk_idx;
    chk_done_n    = 1'b0;
    chk_miss_n    = 1'b0;
    wr_en         = 1'b0;
    if (clear) begin
      state_n      = IDLE;
      length_n     = '0;
      rd_ptr_n     = '0;
      play_valid_n = 1'b0;
      chk_idx_n    = '0;
    end else begin
      case (state)
        IDLE: begin
          // A load request always consumes the cycle, even when it is discarded.
          if (load) begin
            if (!full) begin
              wr_en    = 1'b1;
              length_n = length + LEN_W'(1);
            end
          end else if (play_start && (length != '0)) begin
            state_n       = PLAY;
            rd_ptr_n      = '0;
            play_colour_n = mem[0];
            play_valid_n  = 1'b1;
          end else if (chk_start && (length != '0)) begin
            state_n   = CHECK;
            chk_idx_n = '0;
          end
        end
        PLAY: begin
          if (play_adv && play_valid) begin
            if (rd_ptr == last_idx) begin
              play_valid_n = 1'b0;
              state_n      = IDLE;
            end else begin
              rd_ptr_n      = rd_ptr_inc;
              play_colour_n = mem[rd_ptr_inc[IDX_W-1:0]];
            end
          end
        end
        CHECK: begin
          if (chk_valid) begin
            if (chk_colour != mem[chk_idx[IDX_W-1:0]]) begin
              chk_miss_n = 1'b1;
              state_n    = IDLE;
            end else if (chk_idx == last_idx) begin
              chk_done_n = 1'b1;
              state_n    = IDLE;
            end else begin
              chk_idx_n = chk_idx + LEN_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      length      <= '0;
      rd_ptr      <= '0;
      play_colour <= '0;
      play_valid  <= 1'b0;
      chk_idx     <= '0;
      chk_done    <= 1'b0;
      chk_miss    <= 1'b0;
    end else begin
      state       <= state_n;
      length      <= length_n;
      rd_ptr      <= rd_ptr_n;
      play_colour <= play_colour_n;
      play_valid  <= play_valid_n;
      chk_idx     <= chk_idx_n;
      chk_done    <= chk_done_n;
      chk_miss    <= chk_miss_n;
    end
  end

  // Storage has no reset; length alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[length[IDX_W-1:0]] <= new_colour;
  end

`ifdef SEQ_STORE_SNAPSHOT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_flat <= '0;
    end else if (clear) begin
      seq_flat <= '0;
    end else if (wr_en) begin
      seq_flat[int'(length[IDX_W-1:0]) * COLOUR_W +: COLOUR_W] <= new_colour;
    end
  end
`endif

endmodule
